// File: rtl/network_source.sv
// Host-stream to network adapter: collects per-input charges from command words
// and issues network steps (or a clear) carrying that frame.
module network_source #(
  parameter  int NUM_INP      = 4,
  parameter  int CHARGE_WIDTH = 8,
  parameter  int RUN_WIDTH    = 8,
  localparam int IDX_WIDTH    = (NUM_INP > 1) ? $clog2(NUM_INP) : 1,
  localparam int PAY_WIDTH    = (CHARGE_WIDTH > RUN_WIDTH) ? CHARGE_WIDTH : RUN_WIDTH,
  localparam int SRC_WIDTH    = 2 + IDX_WIDTH + PAY_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            src_valid,
  output logic                            src_ready,
  input  logic [SRC_WIDTH-1:0]            src,
  input  logic                            net_ready,
  output logic                            net_valid,
  output logic                            net_clear,
  output logic [NUM_INP*CHARGE_WIDTH-1:0] net_inp
);

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_RUN,
    ST_CLEAR
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SPK = 2'b01;
  localparam logic [1:0] OP_RUN = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t                            state_q, state_d;
  logic [NUM_INP*CHARGE_WIDTH-1:0]   frame_q, frame_d;
  logic [RUN_WIDTH-1:0]              remaining_q, remaining_d;
  logic                              net_valid_q, net_valid_d;
  logic                              net_clear_q, net_clear_d;

  logic [1:0]                        src_op;
  logic [IDX_WIDTH-1:0]              src_idx;
  logic [PAY_WIDTH-1:0]              src_pay;
  logic [31:0]                       idx_ext;
  logic [RUN_WIDTH-1:0]              run_len;
  logic                              src_fire;
  logic                              net_fire;

  assign src_op    = src[SRC_WIDTH-1 -: 2];
  assign src_idx   = src[PAY_WIDTH +: IDX_WIDTH];
  assign src_pay   = src[PAY_WIDTH-1:0];
  assign idx_ext   = 32'(src_idx);
  assign run_len   = src_pay[RUN_WIDTH-1:0];

  assign src_ready = (state_q == ST_ACCEPT) && !rst;
  assign src_fire  = src_valid && src_ready;
  assign net_fire  = net_valid_q && net_ready;

  assign net_valid = net_valid_q;
  assign net_clear = net_clear_q;
  assign net_inp   = frame_q;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    remaining_d = remaining_q;
    net_valid_d = net_valid_q;
    net_clear_d = net_clear_q;

    case (state_q)
      ST_ACCEPT: begin
        if (src_fire) begin
          case (src_op)
            OP_NOP: ;
            // Only in-range indices match a slot; out-of-range SPK words fall through unused.
            OP_SPK: begin
              for (int i = 0; i < NUM_INP; i++) begin
                if (idx_ext == 32'(i)) begin
                  frame_d[i*CHARGE_WIDTH +: CHARGE_WIDTH] = src_pay[CHARGE_WIDTH-1:0];
                end
              end
            end
            OP_RUN: begin
              if (run_len != '0) begin
                remaining_d = run_len;
                net_valid_d = 1'b1;
                net_clear_d = 1'b0;
                state_d     = ST_RUN;
              end
            end
            OP_CLR: begin
              net_valid_d = 1'b1;
              net_clear_d = 1'b1;
              state_d     = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end

      // Charges ride only on the first step of a run; later steps carry zeros.
      ST_RUN: begin
        if (net_fire) begin
          frame_d     = '0;
          remaining_d = remaining_q - RUN_WIDTH'(1);
          if (remaining_q == RUN_WIDTH'(1)) begin
            net_valid_d = 1'b0;
            state_d     = ST_ACCEPT;
          end
        end
      end

      ST_CLEAR: begin
        if (net_fire) begin
          frame_d     = '0;
          net_valid_d = 1'b0;
          net_clear_d = 1'b0;
          state_d     = ST_ACCEPT;
        end
      end

      default: begin
        state_d     = ST_ACCEPT;
        net_valid_d = 1'b0;
        net_clear_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      frame_q     <= '0;
      remaining_q <= '0;
      net_valid_q <= 1'b0;
      net_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      remaining_q <= remaining_d;
      net_valid_q <= net_valid_d;
      net_clear_q <= net_clear_d;
    end
  end

endmodule

// File: tb/tb_network_source.sv
// Bench for network_source: directed scenarios plus random command streams,
// checked cycle by cycle against a queue-based model of expected network transfers.
module tb_network_source;

  localparam int NI = 5;
  localparam int CW = 6;
  localparam int RW = 8;
  localparam int IW = 3;
  localparam int PW = 8;
  localparam int SW = 2 + IW + PW;
  localparam int FW = NI * CW;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SPK = 2'b01;
  localparam logic [1:0] OP_RUN = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_valid;
  logic          src_ready;
  logic [SW-1:0] src;
  logic          net_ready;
  logic          net_valid;
  logic          net_clear;
  logic [FW-1:0] net_inp;

  typedef struct {
    bit            clr;
    logic [FW-1:0] inp;
  } xfer_t;

  xfer_t         exp_q[$];
  logic [SW-1:0] cmd_q[$];
  logic [CW-1:0] charge_m[NI];

  int checks = 0;
  int passed = 0;

  network_source #(
    .NUM_INP      (NI),
    .CHARGE_WIDTH (CW),
    .RUN_WIDTH    (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src       (src),
    .net_ready (net_ready),
    .net_valid (net_valid),
    .net_clear (net_clear),
    .net_inp   (net_inp)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] mk(input logic [1:0] op, input int idx, input int pay);
    logic [IW-1:0] i_f;
    logic [PW-1:0] p_f;
    i_f = IW'(idx);
    p_f = PW'(pay);
    return {op, i_f, p_f};
  endfunction

  function automatic logic [FW-1:0] frame_m();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NI; i++) f[i*CW +: CW] = charge_m[i];
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Model of an accepted command: the frame is a set of slots, and a RUN or CLR
  // turns into a list of transfers the network must see, in order.
  task automatic applyStimulus(input logic [SW-1:0] w);
    logic [1:0]    op;
    int            idx;
    int            pay;
    xfer_t         x;
    op  = w[SW-1 -: 2];
    idx = int'(w[PW +: IW]);
    pay = int'(w[PW-1:0]);
    case (op)
      OP_SPK: if (idx < NI) charge_m[idx] = CW'(pay % (1 << CW));
      OP_RUN: begin
        for (int k = 0; k < pay % (1 << RW); k++) begin
          x.clr = 1'b0;
          x.inp = (k == 0) ? frame_m() : '0;
          exp_q.push_back(x);
        end
        if (pay % (1 << RW) != 0) for (int i = 0; i < NI; i++) charge_m[i] = '0;
      end
      OP_CLR: begin
        x.clr = 1'b1;
        x.inp = frame_m();
        exp_q.push_back(x);
        for (int i = 0; i < NI; i++) charge_m[i] = '0;
      end
      default: ;
    endcase
  endtask

  task automatic tick(input bit rdy);
    bit exp_nv, exp_sr, do_src, do_net;
    src_valid = (cmd_q.size() > 0);
    src       = src_valid ? cmd_q[0] : SW'($urandom);
    net_ready = rdy;
    #1;
    exp_nv = (exp_q.size() > 0);
    exp_sr = !exp_nv && !rst;
    checkOutput("src_ready", 64'(src_ready), 64'(exp_sr));
    checkOutput("net_valid", 64'(net_valid), 64'(exp_nv));
    if (exp_nv) begin
      checkOutput("net_clear", 64'(net_clear), 64'(exp_q[0].clr));
      checkOutput("net_inp_step", 64'(net_inp), 64'(exp_q[0].inp));
    end else begin
      checkOutput("net_clear_idle", 64'(net_clear), 64'(0));
      checkOutput("net_inp_frame", 64'(net_inp), 64'(frame_m()));
    end
    do_src = exp_sr && src_valid;
    do_net = exp_nv && rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NI; i++) charge_m[i] = '0;
    end else begin
      if (do_src) applyStimulus(cmd_q.pop_front());
      if (do_net) void'(exp_q.pop_front());
    end
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    checkOutput("drain_budget", 64'(cmd_q.size() == 0 && exp_q.size() == 0), 64'(1));
    tick(1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NI; i++) charge_m[i] = '0;
    rst       = 1'b1;
    src_valid = 1'b1;
    src       = '0;
    net_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a pending command: nothing accepted, nothing issued.
    cmd_q.push_back(mk(OP_NOP, 0, 0));
    for (int k = 0; k < 3; k++) tick(1'b1);
    rst = 1'b0;
    drain(1'b0, 20);

    // First step carries the charges (upper payload bits of the -2 word ignored).
    cmd_q.push_back(mk(OP_SPK, 0, 5));
    cmd_q.push_back(mk(OP_SPK, 3, 8'hFE));
    cmd_q.push_back(mk(OP_RUN, 0, 3));
    drain(1'b0, 50);

    // Last write wins, step held through a four-cycle stall.
    cmd_q.push_back(mk(OP_SPK, 1, 7));
    cmd_q.push_back(mk(OP_SPK, 1, 9));
    cmd_q.push_back(mk(OP_RUN, 0, 1));
    n = 0;
    while (cmd_q.size() > 0 && n < 20) begin
      tick(1'b0);
      n++;
    end
    checkOutput("stall_setup", 64'(cmd_q.size()), 64'(0));
    for (int k = 0; k < 4; k++) tick(1'b0);
    drain(1'b0, 20);

    // Clear consumes the pending charge; the next run carries zeros.
    cmd_q.push_back(mk(OP_SPK, 0, 4));
    cmd_q.push_back(mk(OP_CLR, 0, 0));
    cmd_q.push_back(mk(OP_RUN, 0, 1));
    drain(1'b0, 20);

    // Zero-length run and out-of-range indices are no-ops; frame retained.
    cmd_q.push_back(mk(OP_SPK, 2, 8'hC5));
    cmd_q.push_back(mk(OP_RUN, 0, 0));
    cmd_q.push_back(mk(OP_SPK, 5, 17));
    cmd_q.push_back(mk(OP_SPK, 7, 3));
    drain(1'b0, 20);
    for (int k = 0; k < 3; k++) tick(1'b1);

    // Longest run: 255 steps, no wrap-around.
    cmd_q.push_back(mk(OP_RUN, 0, 255));
    drain(1'b0, 400);

    // Reset during the second step of a ten-step run.
    cmd_q.push_back(mk(OP_SPK, 4, 11));
    cmd_q.push_back(mk(OP_RUN, 0, 10));
    n = 0;
    while (!(cmd_q.size() == 0 && exp_q.size() == 9) && n < 50) begin
      tick(1'b1);
      n++;
    end
    checkOutput("reset_mid_run_reached", 64'(exp_q.size()), 64'(9));
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick(1'b1);

    // Random command bursts with random backpressure.
    for (int it = 0; it < 150; it++) begin
      int burst;
      burst = $urandom_range(1, 3);
      for (int b = 0; b < burst; b++) begin
        logic [1:0] op;
        int         pay;
        op  = 2'($urandom_range(0, 3));
        pay = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        if (op == OP_SPK) pay = $urandom_range(0, 255);
        cmd_q.push_back(mk(op, $urandom_range(0, 7), pay));
      end
      drain(1'b1, 2000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
